// File: rtl/ttt_turn_controller_pkg.sv
// Shared definitions for the tic-tac-toe turn controller: slot codes, FSM
// encodings and the eight winning lines.
package ttt_turn_controller_pkg;

  localparam int NUM_SLOTS = 9;
  localparam int NUM_LINES = 8;
  localparam int BOARD_W   = 2 * NUM_SLOTS;

  localparam logic [1:0] SLOT_EMPTY = 2'b00;
  localparam logic [1:0] SLOT_X     = 2'b01;
  localparam logic [1:0] SLOT_O     = 2'b10;

  localparam logic [3:0] MOVES_FULL = 4'd9;

  // state    | meaning
  // ST_PLAY  | waiting for the player on turn to step the cursor or place
  // ST_CHECK | one cycle: judge the board just written
  // ST_OVER  | game finished, board and winner frozen
  localparam logic [1:0] ST_PLAY  = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_OVER  = 2'd2;

  // Slot triples: rows, columns, diagonals.
  localparam logic [3:0] WIN_LINES [NUM_LINES][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

  function automatic logic [1:0] player_code(input logic player);
    return player ? SLOT_O : SLOT_X;
  endfunction

endpackage

// File: rtl/ttt_turn_controller_win_detect.sv
// Combinational three-in-a-row detector for one player over the whole board.
module ttt_win_detect
  import ttt_turn_controller_pkg::*;
(
  input  logic [BOARD_W-1:0] board,
  input  logic               player,
  output logic               win
);

  logic [1:0]           slots [NUM_SLOTS];
  logic [1:0]           code;
  logic [NUM_LINES-1:0] line_hit;

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    assign slots[i] = board[2*i+1:2*i];
  end

  always_comb begin
    code     = player_code(player);
    line_hit = '0;
    for (int l = 0; l < NUM_LINES; l++) begin
      line_hit[l] = (slots[WIN_LINES[l][0]] == code) &&
                    (slots[WIN_LINES[l][1]] == code) &&
                    (slots[WIN_LINES[l][2]] == code);
    end
  end

  assign win = |line_hit;

endmodule

// File: rtl/ttt_turn_controller.sv
// Tic-tac-toe game sequencer: shared slot cursor, turn ownership, board
// register, placement accept/reject, win/draw judgement and turn timeout.
module ttt_turn_controller
  import ttt_turn_controller_pkg::*;
#(
  parameter logic [3:0]  START_SLOT     = 4'd8,
  parameter logic        FIRST_PLAYER   = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter int unsigned TO_W           = 24
) (
  input  logic               clk,
  input  logic               counter_reset,
  input  logic               new_game,
  input  logic [1:0]         next_btn,
  input  logic [1:0]         place_btn,
  output logic [3:0]         cursor,
  output logic               turn,
  output logic [BOARD_W-1:0] board,
  output logic               move_ack,
  output logic               move_nak,
  output logic               timeout,
  output logic               game_over,
  output logic [1:0]         winner
);

  localparam bit              TIMER_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_W-1:0] TO_LAST  =
    TO_W'((TIMEOUT_CYCLES != 0) ? (TIMEOUT_CYCLES - 1) : 0);

  logic [1:0]         state_q,     state_d;
  logic [3:0]         cursor_q,    cursor_d;
  logic               turn_q,      turn_d;
  logic [BOARD_W-1:0] board_q,     board_d;
  logic [3:0]         moves_q,     moves_d;
  logic [TO_W-1:0]    timer_q,     timer_d;
  logic [1:0]         winner_q,    winner_d;
  logic               game_over_q, game_over_d;
  logic               ack_q,       ack_d;
  logic               nak_q,       nak_d;
  logic               timeout_q,   timeout_d;
  logic [1:0]         next_q,      next_d;
  logic [1:0]         place_q,     place_d;

  logic [1:0]         next_edge, place_edge;
  logic               own_place, own_next, other_place;
  logic [1:0]         slots [NUM_SLOTS];
  logic [1:0]         cur_slot;
  logic [BOARD_W-1:0] board_placed;
  logic               place_ok;
  logic               timer_hit;
  logic               win;

  assign next_edge   = next_btn  & ~next_q;
  assign place_edge  = place_btn & ~place_q;
  assign own_place   = place_edge[turn_q];
  assign own_next    = next_edge[turn_q];
  assign other_place = place_edge[~turn_q];

  // Board seen as slots for the occupancy test, and a copy with the
  // cursor slot overwritten by the current player's mark.
  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    assign slots[i] = board_q[2*i+1:2*i];
    assign board_placed[2*i+1:2*i] =
      (cursor_q == 4'(i)) ? player_code(turn_q) : board_q[2*i+1:2*i];
  end

  assign cur_slot  = (cursor_q < 4'(NUM_SLOTS)) ? slots[cursor_q] : SLOT_O;
  assign place_ok  = (state_q == ST_PLAY) && own_place && (cur_slot == SLOT_EMPTY);
  assign timer_hit = TIMER_EN && (timer_q == TO_LAST);

  ttt_win_detect u_win_detect (
    .board  (board_q),
    .player (turn_q),
    .win    (win)
  );

  always_comb begin
    state_d     = state_q;
    cursor_d    = cursor_q;
    turn_d      = turn_q;
    board_d     = board_q;
    moves_d     = moves_q;
    timer_d     = timer_q;
    winner_d    = winner_q;
    game_over_d = game_over_q;
    ack_d       = 1'b0;
    nak_d       = 1'b0;
    timeout_d   = 1'b0;
    next_d      = next_btn;
    place_d     = place_btn;

    if (new_game) begin
      state_d     = ST_PLAY;
      cursor_d    = START_SLOT;
      turn_d      = FIRST_PLAYER;
      board_d     = '0;
      moves_d     = '0;
      timer_d     = '0;
      winner_d    = SLOT_EMPTY;
      game_over_d = 1'b0;
      next_d      = 2'b11;
      place_d     = 2'b11;
    end else begin
      case (state_q)
        ST_PLAY: begin
          if (place_ok) begin
            board_d = board_placed;
            moves_d = moves_q + 4'd1;
            ack_d   = 1'b1;
            timer_d = '0;
            state_d = ST_CHECK;
          end else begin
            if (own_place) begin
              nak_d = 1'b1;
            end else if (own_next) begin
              cursor_d = (cursor_q == 4'd0) ? START_SLOT : (cursor_q - 4'd1);
            end
            if (other_place) begin
              nak_d = 1'b1;
            end
            // Forfeit wins over a rejected placement in the same cycle.
            if (TIMER_EN) begin
              if (timer_hit) begin
                timeout_d = 1'b1;
                nak_d     = 1'b0;
                turn_d    = ~turn_q;
                cursor_d  = START_SLOT;
                timer_d   = '0;
              end else begin
                timer_d = timer_q + 1'b1;
              end
            end
          end
        end
        ST_CHECK: begin
          if (win) begin
            winner_d    = player_code(turn_q);
            game_over_d = 1'b1;
            state_d     = ST_OVER;
          end else if (moves_q == MOVES_FULL) begin
            winner_d    = SLOT_EMPTY;
            game_over_d = 1'b1;
            state_d     = ST_OVER;
          end else begin
            turn_d   = ~turn_q;
            cursor_d = START_SLOT;
            timer_d  = '0;
            state_d  = ST_PLAY;
          end
        end
        ST_OVER: begin
          state_d = ST_OVER;
        end
        default: begin
          state_d = ST_PLAY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge counter_reset) begin
    if (counter_reset) begin
      state_q     <= ST_PLAY;
      cursor_q    <= START_SLOT;
      turn_q      <= FIRST_PLAYER;
      board_q     <= '0;
      moves_q     <= '0;
      timer_q     <= '0;
      winner_q    <= SLOT_EMPTY;
      game_over_q <= 1'b0;
      ack_q       <= 1'b0;
      nak_q       <= 1'b0;
      timeout_q   <= 1'b0;
      next_q      <= 2'b11;
      place_q     <= 2'b11;
    end else begin
      state_q     <= state_d;
      cursor_q    <= cursor_d;
      turn_q      <= turn_d;
      board_q     <= board_d;
      moves_q     <= moves_d;
      timer_q     <= timer_d;
      winner_q    <= winner_d;
      game_over_q <= game_over_d;
      ack_q       <= ack_d;
      nak_q       <= nak_d;
      timeout_q   <= timeout_d;
      next_q      <= next_d;
      place_q     <= place_d;
    end
  end

  assign cursor    = cursor_q;
  assign turn      = turn_q;
  assign board     = board_q;
  assign move_ack  = ack_q;
  assign move_nak  = nak_q;
  assign timeout   = timeout_q;
  assign game_over = game_over_q;
  assign winner    = winner_q;

endmodule

// File: tb/tb_ttt_turn_controller.sv
// Bench for ttt_turn_controller: two instances (timeout off / 16 cycles) share
// stimulus; a game-rule model predicts each cycle and a monitor scores it.
module tb_ttt_turn_controller;

  logic        clk = 1'b0;
  logic        counter_reset;
  logic        new_game;
  logic [1:0]  next_btn, place_btn;

  logic [3:0]  a_cursor, b_cursor;
  logic        a_turn, b_turn;
  logic [17:0] a_board, b_board;
  logic        a_ack, b_ack, a_nak, b_nak, a_to, b_to, a_go, b_go;
  logic [1:0]  a_win, b_win;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ttt_turn_controller #(.START_SLOT(4'd8), .FIRST_PLAYER(1'b0),
                        .TIMEOUT_CYCLES(0), .TO_W(24)) dut_a (
    .clk(clk), .counter_reset(counter_reset), .new_game(new_game),
    .next_btn(next_btn), .place_btn(place_btn),
    .cursor(a_cursor), .turn(a_turn), .board(a_board),
    .move_ack(a_ack), .move_nak(a_nak), .timeout(a_to),
    .game_over(a_go), .winner(a_win)
  );

  ttt_turn_controller #(.START_SLOT(4'd8), .FIRST_PLAYER(1'b0),
                        .TIMEOUT_CYCLES(16), .TO_W(24)) dut_b (
    .clk(clk), .counter_reset(counter_reset), .new_game(new_game),
    .next_btn(next_btn), .place_btn(place_btn),
    .cursor(b_cursor), .turn(b_turn), .board(b_board),
    .move_ack(b_ack), .move_nak(b_nak), .timeout(b_to),
    .game_over(b_go), .winner(b_win)
  );

  // ---------------- reference model (game rules) ----------------
  int         m_board  [2][9];   // 0 empty, 1 X, 2 O
  int         m_cursor [2];
  int         m_turn   [2];
  int         m_timer  [2];
  int         m_winner [2];
  bit         m_over   [2];
  bit         m_judge  [2];      // a mark was just placed, judge it next cycle
  logic [1:0] m_prev_n [2];
  logic [1:0] m_prev_p [2];

  int exp_q0[$];
  int exp_q1[$];

  function automatic int to_cyc(int d);
    return (d == 1) ? 16 : 0;
  endfunction

  function automatic int marks(int d);
    int n = 0;
    for (int i = 0; i < 9; i++) if (m_board[d][i] != 0) n++;
    return n;
  endfunction

  function automatic bit has_line(int d, int who);
    for (int r = 0; r < 3; r++)
      if (m_board[d][3*r] == who && m_board[d][3*r+1] == who && m_board[d][3*r+2] == who) return 1;
    for (int c = 0; c < 3; c++)
      if (m_board[d][c] == who && m_board[d][c+3] == who && m_board[d][c+6] == who) return 1;
    if (m_board[d][0] == who && m_board[d][4] == who && m_board[d][8] == who) return 1;
    if (m_board[d][2] == who && m_board[d][4] == who && m_board[d][6] == who) return 1;
    return 0;
  endfunction

  function automatic logic [17:0] exp_board(int d);
    logic [17:0] v = '0;
    for (int i = 0; i < 9; i++) v[2*i +: 2] = 2'(m_board[d][i]);
    return v;
  endfunction

  task automatic model_reset(int d);
    for (int i = 0; i < 9; i++) m_board[d][i] = 0;
    m_cursor[d] = 8; m_turn[d] = 0; m_timer[d] = 0; m_winner[d] = 0;
    m_over[d] = 0; m_judge[d] = 0; m_prev_n[d] = 2'b11; m_prev_p[d] = 2'b11;
  endtask

  // pulse: 0 none, 1 ack, 2 nak, 4 timeout
  task automatic model_step(int d, bit rst, bit ng, logic [1:0] nb, logic [1:0] pb,
                            output int pulse);
    logic [1:0] pe, ne;
    int own;
    bit took;
    pulse = 0;
    if (rst || ng) begin
      model_reset(d);
      return;
    end
    pe = pb & ~m_prev_p[d];
    ne = nb & ~m_prev_n[d];
    m_prev_p[d] = pb;
    m_prev_n[d] = nb;
    if (m_over[d]) return;
    if (m_judge[d]) begin
      m_judge[d] = 0;
      if (has_line(d, m_turn[d] + 1)) begin
        m_over[d] = 1; m_winner[d] = m_turn[d] + 1;
      end else if (marks(d) == 9) begin
        m_over[d] = 1; m_winner[d] = 0;
      end else begin
        m_turn[d] = 1 - m_turn[d]; m_cursor[d] = 8; m_timer[d] = 0;
      end
      return;
    end
    own  = m_turn[d];
    took = 0;
    if (pe[own]) begin
      if (m_board[d][m_cursor[d]] == 0) begin
        m_board[d][m_cursor[d]] = own + 1;
        pulse = 1; took = 1; m_judge[d] = 1; m_timer[d] = 0;
      end else begin
        pulse = 2;
      end
    end else if (ne[own]) begin
      m_cursor[d] = (m_cursor[d] == 0) ? 8 : m_cursor[d] - 1;
    end
    if (pe[1-own] && pulse == 0) pulse = 2;
    if (!took && to_cyc(d) > 0) begin
      if (m_timer[d] == to_cyc(d) - 1) begin
        pulse = 4; m_turn[d] = 1 - own; m_cursor[d] = 8; m_timer[d] = 0;
      end else begin
        m_timer[d]++;
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_dut(int d, logic [3:0] cur, logic t, logic [17:0] bd,
                           logic ack, logic nak, logic to, logic go, logic [1:0] win);
    int k;
    string tag;
    tag = (d == 0) ? "a" : "b";
    if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
      total++; bad++;
      $display("FAIL %s_queue_underflow got=empty exp=entry", tag);
      return;
    end
    k = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
    chk({tag, "_pulses"},    32'({to, nak, ack}), 32'(k));
    chk({tag, "_cursor"},    32'(cur), 32'(m_cursor[d]));
    chk({tag, "_turn"},      32'(t),   32'(m_turn[d]));
    chk({tag, "_board"},     32'(bd),  32'(exp_board(d)));
    chk({tag, "_game_over"}, 32'(go),  32'(m_over[d]));
    chk({tag, "_winner"},    32'(win), 32'(m_winner[d]));
  endtask

  always @(negedge clk) begin
    check_dut(0, a_cursor, a_turn, a_board, a_ack, a_nak, a_to, a_go, a_win);
    check_dut(1, b_cursor, b_turn, b_board, b_ack, b_nak, b_to, b_go, b_win);
  end

  // ---------------- stimulus ----------------
  task automatic step(bit rst, bit ng, logic [1:0] nb, logic [1:0] pb);
    int p;
    counter_reset = rst;
    new_game      = ng;
    next_btn      = nb;
    place_btn     = pb;
    @(posedge clk);
    model_step(0, rst, ng, nb, pb, p); exp_q0.push_back(p);
    model_step(1, rst, ng, nb, pb, p); exp_q1.push_back(p);
    @(negedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 2'b00, 2'b00);
  endtask

  task automatic press_next(int p);
    logic [1:0] v;
    v = 2'b01 << p;
    step(0, 0, v, 2'b00);
    step(0, 0, 2'b00, 2'b00);
  endtask

  task automatic press_place(int p);
    logic [1:0] v;
    v = 2'b01 << p;
    step(0, 0, 2'b00, v);
    step(0, 0, 2'b00, 2'b00);
  endtask

  task automatic move(int p, int s);
    for (int i = 0; i < 8 - s; i++) press_next(p);
    press_place(p);
  endtask

  initial begin
    int xs[5];
    int os[4];
    xs = '{0, 2, 3, 7, 8};
    os = '{1, 4, 5, 6};

    step(1, 0, 2'b00, 2'b00);
    step(1, 0, 2'b11, 2'b11);
    step(0, 0, 2'b00, 2'b00);
    chk("reset_cursor", 32'(a_cursor), 32'd8);
    chk("reset_turn",   32'(a_turn),   32'd0);
    chk("reset_board",  32'(a_board),  32'd0);
    chk("reset_over",   32'(a_go),     32'd0);

    // X places on slot 8
    step(0, 0, 2'b00, 2'b01);
    chk("t1_board_slot8", 32'(a_board[17:16]), 32'd1);
    chk("t1_ack_n1",      32'(a_ack),          32'd1);
    chk("t1_turn_n1",     32'(a_turn),         32'd0);
    step(0, 0, 2'b00, 2'b00);
    chk("t1_turn_n2",     32'(a_turn),   32'd1);
    chk("t1_cursor_n2",   32'(a_cursor), 32'd8);

    // O walks the cursor all the way round
    for (int i = 0; i < 9; i++) begin
      press_next(1);
      chk("t2_cursor_walk", 32'(a_cursor), (i < 8) ? 32'(7 - i) : 32'd8);
    end
    press_next(0);
    chk("t2_x_next_ignored", 32'(a_cursor), 32'd8);

    // O on occupied slot, then X out of turn
    step(0, 0, 2'b00, 2'b10);
    chk("t3_nak_occupied", 32'(a_nak),          32'd1);
    chk("t3_board_kept",   32'(a_board[17:16]), 32'd1);
    chk("t3_turn_kept",    32'(a_turn),         32'd1);
    step(0, 0, 2'b00, 2'b00);
    step(0, 0, 2'b00, 2'b01);
    chk("t3_nak_wrong_turn", 32'(a_nak), 32'd1);
    step(0, 0, 2'b00, 2'b00);

    // X wins on the 6-7-8 row
    move(1, 5); move(0, 7); move(1, 4); move(0, 6);
    chk("t4_game_over", 32'(a_go),  32'd1);
    chk("t4_winner_x",  32'(a_win), 32'd1);
    press_place(1); press_next(0); press_place(0);
    chk("t4_board_frozen", 32'(a_board), 32'(18'b01_01_01_10_10_00_00_00_00));
    step(0, 1, 2'b00, 2'b00);
    chk("t4_newgame_board", 32'(a_board), 32'd0);
    chk("t4_newgame_turn",  32'(a_turn),  32'd0);
    step(0, 0, 2'b00, 2'b00);

    // Full board, no line
    for (int i = 0; i < 9; i++) begin
      if (i % 2 == 0) move(0, xs[i/2]);
      else            move(1, os[i/2]);
    end
    chk("t5_game_over", 32'(a_go),    32'd1);
    chk("t5_draw",      32'(a_win),   32'd0);
    chk("t5_board",     32'(a_board), 32'(18'b01_01_10_10_10_01_01_10_01));

    // Reset while judging a move
    step(0, 1, 2'b00, 2'b00);
    step(0, 0, 2'b00, 2'b00);
    step(0, 0, 2'b00, 2'b01);
    counter_reset = 1'b1;
    model_reset(0);
    model_reset(1);
    #1;
    chk("t5_rst_cursor", 32'(a_cursor), 32'd8);
    chk("t5_rst_turn",   32'(a_turn),   32'd0);
    chk("t5_rst_board",  32'(a_board),  32'd0);
    chk("t5_rst_ack",    32'(a_ack),    32'd0);
    chk("t5_rst_over",   32'(a_go),     32'd0);
    step(1, 0, 2'b00, 2'b00);
    step(0, 0, 2'b00, 2'b00);

    // Timeout on the 16-cycle instance
    step(0, 1, 2'b00, 2'b00);
    idle(15);
    chk("t6_no_timeout_yet", 32'(b_to), 32'd0);
    idle(1);
    chk("t6_timeout",        32'(b_to),     32'd1);
    chk("t6_turn_toggled",   32'(b_turn),   32'd1);
    chk("t6_cursor_start",   32'(b_cursor), 32'd8);
    step(0, 1, 2'b00, 2'b00);
    idle(15);
    step(0, 0, 2'b00, 2'b01);
    chk("t6_place_ack",      32'(b_ack), 32'd1);
    chk("t6_place_no_to",    32'(b_to),  32'd0);
    step(0, 0, 2'b00, 2'b00);

    // Random play
    for (int i = 0; i < 3000; i++) begin
      bit         r, g;
      logic [1:0] nb, pb;
      r  = ($urandom_range(0, 499) == 0);
      g  = ($urandom_range(0, 149) == 0);
      nb = {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
      pb = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
      step(r, g, nb, pb);
    end
    step(0, 0, 2'b00, 2'b00);

    chk("queue_a_drained", 32'(exp_q0.size()), 32'd0);
    chk("queue_b_drained", 32'(exp_q1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
